spi_frame_decoder: RTL and testbench
====================================

Name: spi_frame_decoder

Overview:
- Sits directly downstream of the SPI slave, in the system `clk` domain.
- Consumes received bytes and assembles fixed-length command frames from the MCU: header, DATA_BYTES payload bytes, XOR checksum.
- Issues single-cycle register writes and clear-all strobes to the synth parameter register file.
- Serves readback by supplying the slave's transmit byte.

Parameters:
- ADDR_W, 6, register address width; fixed by header layout, not to be changed.
- DATA_BYTES, 3, payload bytes per frame; write data is 8*DATA_BYTES bits.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; the only clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- byte_in  in  8  received byte from the SPI slave.
- byte_valid  in  1  one-cycle pulse: byte_in holds a new byte.
- csn  in  1  chip select, already synchronised to clk; high = no frame in progress.
- tx_byte  out  8  byte for the slave to shift out during the next SPI byte.
- rd_addr  out  ADDR_W  readback address to the register file.
- rd_data  in  8*DATA_BYTES  register file read data, valid one cycle after rd_addr.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8*DATA_BYTES  write data.
- clear_all  out  1  one-cycle strobe that resets all voices.
- err_cksum  out  1  one-cycle pulse on checksum mismatch.
- err_abort  out  1  one-cycle pulse when csn rises mid-frame.
- err_count  out  ERR_CNT_W  saturating count of err_cksum plus err_abort events.

Behaviour:
- Reset: all outputs 0, state IDLE, shadow registers cleared.
- Header byte:
  - bits [7:6] = cmd: 00 NOP, 01 WRITE, 10 READ, 11 CLEAR.
  - bits [5:0] = addr.
- Frame format:
  - Every frame is exactly 1 + DATA_BYTES + 1 bytes, regardless of cmd.
  - Checksum is the XOR of all preceding bytes in the frame.
  - Payload is little-endian: the first payload byte is wr_data[7:0].
- States:
  - IDLE: waits for csn low and byte_valid; latches header, seeds checksum accumulator, byte counter = 0 → DATA.
  - DATA: on each byte_valid, stores the byte at lane counter, XORs it into the accumulator, increments counter. After DATA_BYTES bytes → CKSUM.
  - CKSUM: on byte_valid, compares the byte to the accumulator.
    - Match: the next cycle pulses wr_en (WRITE) or clear_all (CLEAR); NOP and READ have no effect. → DROP.
    - Mismatch: pulses err_cksum and increments err_count. → DROP.
  - DROP: ignores further bytes until csn high → IDLE.
- csn high:
  - In any state, csn high forces IDLE in the same cycle.
  - csn high in DATA or CKSUM also pulses err_abort and increments err_count.
  - csn high has priority over a coincident byte_valid; that byte is discarded.
- Writes:
  - wr_addr and wr_data are registered and held stable until the next write.
  - wr_en is never asserted for an aborted or bad-checksum frame.
- Read:
  - When a READ header is accepted, rd_addr = addr on the following cycle.
  - rd_data is captured into a shadow register one cycle later.
  - tx_byte = shadow byte 0 after capture, then advances one lane per payload byte_valid.
  - A checksum failure on READ has no side effects beyond the error outputs.
- tx_byte outside READ frames is 0x00. It returns to 0x00 on entering IDLE.
- err_count saturates at all-ones and never wraps.
- The upstream slave supplies byte_valid at most once per 8 SPI clocks, so back-to-back pulses on consecutive clk cycles need not be handled. Any two byte_valid pulses are at least 2 clk apart.

Decomposition:
- Shared synth package holds:
  - command encodings CMD_NOP, CMD_WRITE, CMD_READ, CMD_CLEAR;
  - header field positions;
  - ADDR_W;
  - a state enum typedef.
- One natural sub-module: spi_frame_cksum, an XOR accumulator with clear and load ports.
- The FSM, payload shift register and read shadow stay in the top module.

Test Plan:
- WRITE: csn low; send 0x45, 0x12, 0x34, 0x56, 0x35 → one wr_en pulse the cycle after the last byte, wr_addr=5, wr_data=0x563412, no errors.
- Bad checksum: same frame with last byte 0x36 → no wr_en, one err_cksum pulse, err_count=1.
- Abort: send 0x45, 0x12, then raise csn → err_abort pulse, err_count increments, no wr_en. A following valid frame writes correctly.
- READ: rd_data=0xABCDEF; send 0x87, 0x00, 0x00, 0x00, 0x87 → rd_addr=7. tx_byte reads 0xEF before the 2nd byte, 0xCD before the 3rd, 0xAB before the 4th. No wr_en.
- CLEAR plus trailing bytes: send 0xC0, 0x00, 0x00, 0x00, 0xC0, then 0xFF, 0xFF before csn high → exactly one clear_all pulse; the extra bytes are ignored.
- Reset mid-frame: assert rstn low after the 2nd payload byte → all outputs 0 immediately. After release, a full WRITE frame works and err_count=0.

Source files
------------

// File: rtl/spi_frame_decoder_pkg.sv
// Shared definitions for the SPI command frame decoder: header layout, commands, FSM states.
package spi_frame_decoder_pkg;

  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned HDR_CMD_MSB  = 7;
  localparam int unsigned HDR_CMD_LSB  = 6;
  localparam int unsigned HDR_ADDR_MSB = 5;
  localparam int unsigned HDR_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef struct packed {
    cmd_e              cmd;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CKSUM,
    ST_DROP
  } state_e;

  // Split a raw header byte into command and register address.
  function automatic hdr_t decode_hdr(input logic [7:0] b);
    hdr_t h;
    h.cmd  = cmd_e'(b[HDR_CMD_MSB:HDR_CMD_LSB]);
    h.addr = b[HDR_ADDR_MSB:HDR_ADDR_LSB];
    return h;
  endfunction

endpackage

// File: rtl/spi_frame_cksum.sv
// Running XOR checksum of a frame: seeded by the header, folded with each payload byte.
module spi_frame_cksum (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       load,
  input  logic       add,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= 8'h00;
    end else if (clear) begin
      acc <= 8'h00;
    end else if (load) begin
      acc <= din;
    end else if (add) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/spi_frame_decoder.sv
// Assembles fixed-length MCU command frames from SPI bytes into register-file writes,
// clear strobes and readback bytes.
module spi_frame_decoder
  import spi_frame_decoder_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 3,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    csn,
  output logic [7:0]              tx_byte,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    clear_all,
  output logic                    err_cksum,
  output logic                    err_abort,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int unsigned DATA_W = 8 * DATA_BYTES;
  localparam int unsigned CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  state_e                     state_q, state_d;
  hdr_t                       hdr_q;
  hdr_t                       hdr_in;
  logic [CNT_W-1:0]           cnt_q;
  logic [DATA_BYTES-1:0][7:0] payload_q;
  logic [DATA_W-1:0]          shadow_q;
  logic [1:0]                 rd_pipe_q;
  logic [7:0]                 acc;
  logic                       hdr_take, pay_take, ck_take, abort_hit;
  logic                       ck_ok, ck_bad;

  assign hdr_in  = decode_hdr(byte_in);
  assign ck_ok   = ck_take && (byte_in == acc);
  assign ck_bad  = ck_take && (byte_in != acc);
  assign tx_byte = shadow_q[7:0];

  spi_frame_cksum u_cksum (
    .clk  (clk),
    .rstn (rstn),
    .clear(csn),
    .load (hdr_take),
    .add  (pay_take),
    .din  (byte_in),
    .acc  (acc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // csn high wins over any coincident byte and always returns to IDLE.
  always_comb begin
    state_d   = state_q;
    hdr_take  = 1'b0;
    pay_take  = 1'b0;
    ck_take   = 1'b0;
    abort_hit = 1'b0;
    if (csn) begin
      state_d   = ST_IDLE;
      abort_hit = (state_q == ST_DATA) || (state_q == ST_CKSUM);
    end else if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          hdr_take = 1'b1;
          state_d  = ST_DATA;
        end
        ST_DATA: begin
          pay_take = 1'b1;
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) state_d = ST_CKSUM;
        end
        ST_CKSUM: begin
          ck_take = 1'b1;
          state_d = ST_DROP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_q     <= '0;
      cnt_q     <= '0;
      payload_q <= '0;
      shadow_q  <= '0;
      rd_pipe_q <= '0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      clear_all <= 1'b0;
      err_cksum <= 1'b0;
      err_abort <= 1'b0;
      err_count <= '0;
    end else begin
      wr_en     <= ck_ok && (hdr_q.cmd == CMD_WRITE);
      clear_all <= ck_ok && (hdr_q.cmd == CMD_CLEAR);
      err_cksum <= ck_bad;
      err_abort <= abort_hit;
      if ((ck_bad || abort_hit) && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
      if (hdr_take) begin
        hdr_q <= hdr_in;
        cnt_q <= '0;
      end
      if (pay_take) begin
        payload_q[cnt_q] <= byte_in;
        cnt_q            <= cnt_q + CNT_W'(1);
      end
      if (ck_ok && (hdr_q.cmd == CMD_WRITE)) begin
        wr_addr <= hdr_q.addr;
        wr_data <= payload_q;
      end
      if (hdr_take && (hdr_in.cmd == CMD_READ)) rd_addr <= hdr_in.addr;
      // Read shadow: captured two cycles after the READ header, then one lane per payload byte.
      rd_pipe_q <= csn ? 2'b00 : {rd_pipe_q[0], hdr_take && (hdr_in.cmd == CMD_READ)};
      if (csn)               shadow_q <= '0;
      else if (rd_pipe_q[1]) shadow_q <= rd_data;
      else if (pay_take)     shadow_q <= shadow_q >> 8;
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: write, bad checksum, abort, read, clear, reset, saturation.
module tb_spi_frame_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        csn;
  logic [7:0]  tx_byte;
  logic [5:0]  rd_addr;
  logic [23:0] rd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;
  logic        clear_all;
  logic        err_cksum;
  logic        err_abort;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses = 0, clr_pulses = 0, ck_pulses = 0, ab_pulses = 0;
  int wr0, clr0, ck0, ab0;

  spi_frame_decoder dut (
    .clk       (clk),
    .rstn      (rstn),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .csn       (csn),
    .tx_byte   (tx_byte),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_all (clear_all),
    .err_cksum (err_cksum),
    .err_abort (err_abort),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en)     wr_pulses++;
    if (clear_all) clr_pulses++;
    if (err_cksum) ck_pulses++;
    if (err_abort) ab_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    wr0 = wr_pulses; clr0 = clr_pulses; ck0 = ck_pulses; ab0 = ab_pulses;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"},    32'(tx_byte),   32'h0);
    check({tag, "_rdad"},  32'(rd_addr),   32'h0);
    check({tag, "_wren"},  32'(wr_en),     32'h0);
    check({tag, "_wrad"},  32'(wr_addr),   32'h0);
    check({tag, "_wrdt"},  32'(wr_data),   32'h0);
    check({tag, "_clr"},   32'(clear_all), 32'h0);
    check({tag, "_eck"},   32'(err_cksum), 32'h0);
    check({tag, "_eab"},   32'(err_abort), 32'h0);
    check({tag, "_ecnt"},  32'(err_count), 32'h0);
  endtask

  initial begin
    rstn = 1'b0; csn = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; rd_data = 24'h0;
    gap(3);
    check_all_zero("reset");
    rstn = 1'b1;
    gap(2);

    // WRITE addr 5, data 0x563412, checksum 0x35
    snap();
    csn = 1'b0;
    send(8'h45); send(8'h12); send(8'h34); send(8'h56); send(8'h35);
    check("wr_en_pulse", 32'(wr_en),     32'h1);
    check("wr_addr",     32'(wr_addr),   32'h05);
    check("wr_data",     32'(wr_data),   32'h563412);
    check("wr_tx_zero",  32'(tx_byte),   32'h0);
    gap(1);
    check("wr_en_single", 32'(wr_en),    32'h0);
    csn = 1'b1;
    gap(2);
    check("wr_count",    32'(wr_pulses - wr0), 32'd1);
    check("wr_no_err",   32'(err_count), 32'h0);

    // Bad checksum
    snap();
    csn = 1'b0;
    send(8'h45); send(8'h12); send(8'h34); send(8'h56); send(8'h36);
    check("bad_eck",     32'(err_cksum), 32'h1);
    check("bad_no_wr",   32'(wr_en),     32'h0);
    check("bad_ecnt",    32'(err_count), 32'h1);
    csn = 1'b1;
    gap(2);
    check("bad_wr_count", 32'(wr_pulses - wr0), 32'd0);
    check("bad_ck_count", 32'(ck_pulses - ck0), 32'd1);
    check("bad_wr_held",  32'(wr_data), 32'h563412);

    // Abort after header and one payload byte
    snap();
    csn = 1'b0;
    send(8'h45); send(8'h12);
    csn = 1'b1;
    gap(1);
    check("abort_pulse", 32'(err_abort), 32'h1);
    check("abort_ecnt",  32'(err_count), 32'h2);
    gap(2);
    check("abort_no_wr", 32'(wr_pulses - wr0), 32'd0);
    check("abort_count", 32'(ab_pulses - ab0), 32'd1);
    // Follow-up good write: addr 0x0A, data 0x030201, checksum 0x4A
    csn = 1'b0;
    send(8'h4A); send(8'h01); send(8'h02); send(8'h03); send(8'h4A);
    check("post_abort_wr_en", 32'(wr_en),   32'h1);
    check("post_abort_addr",  32'(wr_addr), 32'h0A);
    check("post_abort_data",  32'(wr_data), 32'h030201);
    csn = 1'b1;
    gap(2);

    // READ addr 7
    snap();
    rd_data = 24'hABCDEF;
    csn = 1'b0;
    send(8'h87);
    check("rd_addr", 32'(rd_addr), 32'h07);
    gap(3);
    check("rd_tx0", 32'(tx_byte), 32'hEF);
    send(8'h00); gap(2);
    check("rd_tx1", 32'(tx_byte), 32'hCD);
    send(8'h00); gap(2);
    check("rd_tx2", 32'(tx_byte), 32'hAB);
    send(8'h00); gap(2);
    send(8'h87); gap(2);
    csn = 1'b1;
    gap(2);
    check("rd_tx_idle",  32'(tx_byte), 32'h0);
    check("rd_no_wr",    32'(wr_pulses - wr0), 32'd0);
    check("rd_no_err",   32'(err_count), 32'h2);
    rd_data = 24'h0;

    // CLEAR with trailing bytes
    snap();
    csn = 1'b0;
    send(8'hC0); send(8'h00); send(8'h00); send(8'h00); send(8'hC0);
    check("clr_pulse", 32'(clear_all), 32'h1);
    send(8'hFF); send(8'hFF);
    csn = 1'b1;
    gap(2);
    check("clr_count",   32'(clr_pulses - clr0), 32'd1);
    check("clr_no_wr",   32'(wr_pulses - wr0),   32'd0);
    check("clr_no_abrt", 32'(ab_pulses - ab0),   32'd0);
    check("clr_ecnt",    32'(err_count),         32'h2);

    // Reset mid-frame
    csn = 1'b0;
    send(8'h45); send(8'h12); send(8'h34);
    gap(1);
    #2 rstn = 1'b0;
    #1 check_all_zero("midrst");
    gap(2);
    rstn = 1'b1;
    csn = 1'b1;
    gap(2);
    snap();
    csn = 1'b0;
    send(8'h45); send(8'h12); send(8'h34); send(8'h56); send(8'h35);
    check("rst_wr_en",   32'(wr_en),     32'h1);
    check("rst_wr_data", 32'(wr_data),   32'h563412);
    check("rst_ecnt",    32'(err_count), 32'h0);
    csn = 1'b1;
    gap(2);

    // Error counter saturation: 260 aborted frames
    for (int i = 0; i < 260; i++) begin
      csn = 1'b0;
      send(8'h00);
      csn = 1'b1;
      gap(1);
    end
    gap(1);
    check("sat_ecnt", 32'(err_count), 32'hFF);
    csn = 1'b0;
    send(8'h00);
    csn = 1'b1;
    gap(1);
    check("sat_abort_pulse", 32'(err_abort), 32'h1);
    check("sat_hold",        32'(err_count), 32'hFF);
    gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
